melody_player: RTL

- Note sequencer directly upstream of the 50 MHz buzzer tone generator; drives that generator's 32-bit half-period input.
- Software or a test FSM pushes notes into an internal FIFO. Each note is a half-period value and a duration in milliseconds.
- The block plays queued notes back-to-back, inserting a fixed silent gap after each note, and goes silent when the queue drains.

---
 rtl/melody_player.sv | 110 +++++++++++
 1 files changed

// File: rtl/melody_player.sv
// melody_player: FIFO-fed note sequencer driving a buzzer half-period, with a fixed silent gap after each note.
module melody_player #(
   parameter int DEPTH         = 8,
   parameter int CYCLES_PER_MS = 50000,
   parameter int GAP_MS        = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [31:0]              push_halflen,
   input  logic [15:0]              push_dur_ms,
   input  logic                     stop,
   output logic [31:0]              halflen_out,
   output logic                     note_start,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
   localparam logic [15:0] GAP_END = 16'(GAP_MS - 1);
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
   state_t            state, state_n;
   logic [31:0]       mem_half [DEPTH];
   logic [15:0]       mem_dur  [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [PW-1:0]     presc, presc_n;
   logic [15:0]       ms, ms_n, dur, dur_n;
   logic [31:0]       half_n;
   logic              start_n, push_en, pop_en, tick, last_ms;
   assign push_ready = level != LW'(DEPTH);
   assign push_en    = push_valid && push_ready && !stop;
   assign pop_en     = state == IDLE && level != '0 && !stop;
   assign tick       = presc == PW'(CYCLES_PER_MS - 1);
   assign last_ms    = ms == ((state == PLAY) ? dur - 16'd1 : GAP_END);
   assign busy       = state != IDLE || level != '0;
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_half[wr_ptr] <= push_halflen;
         mem_dur[wr_ptr]  <= push_dur_ms;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (stop) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_en);
         rd_ptr <= rd_ptr + AW'(pop_en);
         level  <= level + LW'(push_en) - LW'(pop_en);
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         halflen_out <= '0;
         note_start  <= 1'b0;
         presc       <= '0;
         ms          <= '0;
         dur         <= '0;
      end else begin
         state       <= state_n;
         halflen_out <= half_n;
         note_start  <= start_n;
         presc       <= presc_n;
         ms          <= ms_n;
         dur         <= dur_n;
      end
   end
   // A zero-duration head is popped and dropped without leaving IDLE.
   always_comb begin
      state_n = state;
      half_n  = halflen_out;
      start_n = 1'b0;
      presc_n = presc;
      ms_n    = ms;
      dur_n   = dur;
      if (stop) begin
         state_n = IDLE;
         half_n  = '0;
         presc_n = '0;
         ms_n    = '0;
      end else if (state == IDLE) begin
         half_n = '0;
         if (pop_en && mem_dur[rd_ptr] != 16'd0) begin
            state_n = PLAY;
            half_n  = mem_half[rd_ptr];
            start_n = 1'b1;
            presc_n = '0;
            ms_n    = '0;
            dur_n   = mem_dur[rd_ptr];
         end
      end else begin
         presc_n = tick ? '0 : presc + PW'(1);
         if (tick) begin
            ms_n = last_ms ? '0 : ms + 16'd1;
            if (last_ms) begin
               state_n = (state == PLAY && GAP_MS > 0) ? GAP : IDLE;
               half_n  = '0;
            end
         end
      end
   end
endmodule
